// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: registered VGA test-pattern colour stage.
//
// Ports:
//   i_clk100MHz          sole clock, rising edge
//   i_rst                synchronous active-high reset
//   i_pix_en             pixel strobe; colour register loads only when high
//   i_active, i_x, i_y   visible-region flag and pixel coordinates from the timing stage
//   i_vsync              active-low vertical sync; its falling edge is the frame event
//   i_mode               requested pattern, taken into effect on the next frame event
//   o_red/o_green/o_blue registered 4-bit colour channels
//   o_frame              8-bit frame counter, wraps 255 -> 0
//
// Optional feature: define VGA_PATTERN_SCROLL_EN to scroll modes 0-2 left
// by one pixel per frame (effective column = i_x + o_frame, wrapped once).
module vga_pattern_gen #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic        i_clk100MHz,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic        i_active,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_vsync,
    input  logic [1:0]  i_mode,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic [7:0]  o_frame
);

    localparam logic [11:0] H_LIM = 12'(H_ACT);
    localparam logic [11:0] V_LIM = 12'(V_ACT);
    localparam logic [11:0] HALF  = 12'(H_ACT / 2);
    localparam int          BAR_W = H_ACT / 8;

    logic        vsync_q;
    logic [1:0]  mode_q;
    logic        frame_evt;
    logic [11:0] xe;
    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    logic [11:0] pix_c;

    // Falling edge of the active-low sync marks the start of a frame.
    assign frame_evt = vsync_q & ~i_vsync;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [11:0] x_sum;

    // Single conditional subtract is enough: i_x < H_ACT and o_frame <= 255.
    assign x_sum = i_x + {4'd0, o_frame};
    assign xe    = (x_sum >= H_LIM) ? (x_sum - H_LIM) : x_sum;
`else
    assign xe = i_x;
`endif

    // Bar index from a comparator chain against the bar boundaries.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xe >= 12'(k * BAR_W)) begin
                bar_idx = 3'(k);
            end
        end
    end

    // Colour-bar palette, left to right.
    always_comb begin
        bar_rgb = 12'h000;
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    // Next pixel colour from the latched mode and the pre-update frame count.
    always_comb begin
        pix_c = 12'h000;
        if (i_active && (i_x < H_LIM) && (i_y < V_LIM)) begin
            case (mode_q)
                2'd0:    pix_c = (xe < HALF) ? 12'hF00 : 12'h0F0;
                2'd1:    pix_c = bar_rgb;
                2'd2:    pix_c = (xe[5] ^ i_y[5]) ? 12'hFFF : 12'h000;
                default: pix_c = {i_x[9:6], i_y[8:5], o_frame[7:4]};
            endcase
        end
    end

    // Sync history, mode/frame update on frame events, colour load on strobes.
    always_ff @(posedge i_clk100MHz) begin
        if (i_rst) begin
            vsync_q <= 1'b1;
            mode_q  <= 2'd0;
            o_frame <= 8'd0;
            o_red   <= 4'd0;
            o_green <= 4'd0;
            o_blue  <= 4'd0;
        end else begin
            vsync_q <= i_vsync;
            if (frame_evt) begin
                mode_q  <= i_mode;
                o_frame <= o_frame + 8'd1;
            end
            if (i_pix_en) begin
                o_red   <= pix_c[11:8];
                o_green <= pix_c[7:4];
                o_blue  <= pix_c[3:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen.
// Stimulus pushes the expected colour of every strobe into a queue; a monitor
// pops and compares one entry after each clock edge that carried a strobe.
module tb_vga_pattern_gen;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        active;
    logic [11:0] x;
    logic [11:0] y;
    logic        vsync;
    logic [1:0]  mode;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [7:0]  frame;

    typedef struct {
        logic [11:0] rgb;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [11:0] last_exp = 12'h000;
    logic [7:0]  fr       = 8'd0;

    vga_pattern_gen #(.H_ACT(640), .V_ACT(480)) dut (
        .i_clk100MHz (clk),
        .i_rst       (rst),
        .i_pix_en    (pix_en),
        .i_active    (active),
        .i_x         (x),
        .i_y         (y),
        .i_vsync     (vsync),
        .i_mode      (mode),
        .o_red       (red),
        .o_green     (green),
        .o_blue      (blue),
        .o_frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one scoreboard entry per strobed edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pix_en) begin
                #1;
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: got %03h, no expected entry", {red, green, blue});
                end else begin
                    e = sbq.pop_front();
                    if ({red, green, blue} !== e.rgb) begin
                        failures++;
                        $display("FAIL %s: got %03h expected %03h", e.name, {red, green, blue}, e.rgb);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %03h expected %03h", nm, got, exp);
        end
    endtask

    task automatic strobe(input logic act, input int px, input int py,
                          input logic [11:0] exp, input string nm);
        active = act;
        x      = 12'(px);
        y      = 12'(py);
        pix_en = 1'b1;
        sbq.push_back('{exp, nm});
        last_exp = exp;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        fr = fr + 8'd1;
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; active = 1'b0; x = '0; y = '0;
        vsync = 1'b1; mode = 2'd0;
        repeat (3) @(negedge clk);
        chk("reset_rgb", {red, green, blue}, 12'h000);
        chk("reset_frame", {4'd0, frame}, 12'h000);
        rst = 1'b0;
        @(negedge clk);

        // Split pattern at frame 0.
        strobe(1'b1, 319, 10, 12'hF00, "split_319");
        strobe(1'b1, 320, 10, 12'h0F0, "split_320");
        strobe(1'b0, 100, 10, 12'h000, "inactive");
        strobe(1'b1, 640, 10, 12'h000, "x_out_of_range");
        strobe(1'b1, 10, 480, 12'h000, "y_out_of_range");

        // Latch bars, then request checker mid-frame: bars must persist.
        mode = 2'd1;
        vsync_fall();
        chk("frame_after_1st", {4'd0, frame}, 12'h001);
        mode = 2'd2;
        @(negedge clk);
`ifdef VGA_PATTERN_SCROLL_EN
        strobe(1'b1, 79,  5, 12'hFF0, "bars_79");
        strobe(1'b1, 80,  5, 12'hFF0, "bars_80");
        strobe(1'b1, 559, 5, 12'h000, "bars_559");
        strobe(1'b1, 560, 5, 12'h000, "bars_560");
        strobe(1'b1, 639, 5, 12'hFFF, "scroll_639");
        strobe(1'b1, 0,   5, 12'hFFF, "scroll_0");
`else
        strobe(1'b1, 79,  5, 12'hFFF, "bars_79");
        strobe(1'b1, 80,  5, 12'hFF0, "bars_80");
        strobe(1'b1, 559, 5, 12'h00F, "bars_559");
        strobe(1'b1, 560, 5, 12'h000, "bars_560");
        strobe(1'b1, 639, 5, 12'h000, "noscroll_639");
        strobe(1'b1, 0,   5, 12'hFFF, "noscroll_0");
`endif
        // No strobe: colour must hold while inputs move.
        active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 12'(300 + i * 100);
            @(negedge clk);
            chk("hold", {red, green, blue}, last_exp);
        end

        // Checker takes effect at the next frame event.
        vsync_fall();
        strobe(1'b1, 32, 0,  12'hFFF, "checker_32_0");
        strobe(1'b1, 0,  0,  12'h000, "checker_0_0");
        strobe(1'b1, 0,  32, 12'hFFF, "checker_0_32");

        // Reset mid-line with a strobe in the same cycle and vsync low.
        mode   = 2'd3;
        rst    = 1'b1;
        vsync  = 1'b0;
        strobe(1'b1, 600, 300, 12'h000, "reset_priority");
        chk("midreset_rgb", {red, green, blue}, 12'h000);
        chk("midreset_frame", {4'd0, frame}, 12'h000);
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        rst   = 1'b0;
        fr    = 8'd0;
        repeat (2) @(negedge clk);
        chk("post_reset_frame", {4'd0, frame}, 12'h000);
        strobe(1'b1, 100, 10, 12'hF00, "post_reset_mode0");

        // First event after reset latches gradient and sets frame 1.
        vsync_fall();
        chk("first_evt_frame", {4'd0, frame}, 12'h001);
        strobe(1'b1, 600, 300, 12'h990, "gradient_600_300");

        // Run the counter to 255, then a frame event coincident with a strobe.
        while (fr != 8'd255) vsync_fall();
        chk("frame_255", {4'd0, frame}, 12'h0FF);
        vsync  = 1'b0;
        strobe(1'b1, 0, 0, 12'h00F, "coincident_old_frame");
        vsync  = 1'b1;
        @(negedge clk);
        fr = 8'd0;
        chk("frame_wrap", {4'd0, frame}, 12'h000);
        strobe(1'b1, 0, 0, 12'h000, "gradient_frame0");

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_ACT, default 640: active pixels per line.
REQ-002 Parameter V_ACT, default 480: active lines per frame.
REQ-003 i_clk100MHz  input  1  sole clock; all logic on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_pix_en  input  1  pixel-clock enable strobe, one i_clk100MHz cycle wide, nominally every 4th cycle (25 MHz).
REQ-006 i_active  input  1  high while the timing stage is inside the visible region.
REQ-007 i_x  input  12  active-region pixel column, 0..H_ACT-1, valid when i_active=1.
REQ-008 i_y  input  12  active-region line, 0..V_ACT-1, valid when i_active=1.
REQ-009 i_vsync  input  1  vertical sync from the timing stage, active-low.
REQ-010 i_mode  input  2  requested pattern; asynchronous to frame timing.
REQ-011 o_red, o_green, o_blue  output  4 each  registered pixel colour to the DAC pins.
REQ-012 o_frame  output  8  frame counter.

Function
REQ-013 Block SHALL register i_vsync every clock and detect its falling edge (prev=1, now=0) as the frame event.
REQ-014 On a frame event, block SHALL latch i_mode into the internal mode register and increment o_frame, wrapping 255->0.
REQ-015 i_mode changes between frame events SHALL have no effect on output until the next frame event.
REQ-016 Colour outputs SHALL update only on cycles with i_pix_en=1 and hold otherwise.
REQ-017 Latency: i_active/i_x/i_y sampled on a strobe cycle SHALL appear on o_red/o_green/o_blue after that same clock edge (one register stage).
REQ-018 i_active=0 on a strobe SHALL drive colour 0x000 regardless of mode.
REQ-019 Mode 0 (split): xe < H_ACT/2 -> F,0,0; otherwise 0,F,0.
REQ-020 Mode 1 (bars): eight bars of H_ACT/8 px from left: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000; bar index by comparison, no divider.
REQ-021 Mode 2 (checker): colour FFF if xe[5] XOR i_y[5] = 1, else 000.
REQ-022 Mode 3 (gradient): red = i_x[9:6], green = i_y[8:5], blue = o_frame[7:4]; unaffected by scroll.
REQ-023 xe (effective column) SHALL be i_x unless REQ-029 applies.
REQ-024 i_x >= H_ACT or i_y >= V_ACT with i_active=1 SHALL output 000.
REQ-025 A frame event coinciding with a strobe SHALL use the pre-update mode and frame for that pixel.

Reset
REQ-026 While i_rst=1: colour outputs 0x000, o_frame 0, mode register 0, vsync history register 1.
REQ-027 Reset mid-frame SHALL take effect on the next clock edge; first frame event after release SHALL latch i_mode and set o_frame to 1.
REQ-028 Reset SHALL have priority over i_pix_en and frame events in the same cycle.

Configuration
REQ-029 With VGA_PATTERN_SCROLL_EN defined: xe = i_x + o_frame, minus H_ACT if the sum >= H_ACT (single conditional subtract, 12-bit arithmetic); modes 0-2 scroll left one px per frame.
REQ-030 Without VGA_PATTERN_SCROLL_EN: xe = i_x, no adder synthesized; o_frame still counts.

Verification
REQ-031 Assert i_rst 3 cycles mid-line -> colours 000, o_frame 0 on the edge after first reset cycle; vsync low during reset generates no event.
REQ-032 Mode 0, frame 0, active, strobe with i_x=319 -> F00; i_x=320 -> 0F0; i_active=0 -> 000.
REQ-033 Mode 1 latched, change i_mode to 2 mid-frame -> bars persist; after next vsync fall, i_x=32,i_y=0 -> FFF and i_x=0,i_y=0 -> 000.
REQ-034 Mode 1, strobes at i_x=79,80,559,560 -> FFF, FF0, 00F, 000; no strobe -> outputs hold.
REQ-035 256 vsync falling edges -> o_frame 255 then 0; event coincident with strobe uses old frame per REQ-025.
REQ-036 With VGA_PATTERN_SCROLL_EN, mode 1, o_frame=1, i_x=639 -> FFF (xe=0); i_x=0 -> FFF (xe=1); without macro i_x=639 -> 000.
